mult_div_unit: RTL and testbench

//  EX-stage multiply/divide unit; consumer of the MD control bundle (MDOp, Start, MDWe, HiLo)

---
 rtl/mdu_pkg.sv | 77 +++++++
 rtl/mult_div_unit.sv | 120 ++++++++++++
 tb/tb_mult_div_unit.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - MD operation encodings, HI/LO select constants and result arithmetic
package mdu_pkg;

  // MDOp encodings shared by the ID decoder and the multiply/divide unit
  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3
  } md_op_e;

  // HiLo select values
  localparam logic HILO_LO = 1'b0;
  localparam logic HILO_HI = 1'b1;

  // Idle/busy state of the unit
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  // Result latched at launch: {HI,LO} and whether it is allowed to commit
  typedef struct packed {
    logic [63:0] hilo;
    logic        wr_en;
  } md_result_t;

  // Full 64-bit result of a launched op; a zero divisor suppresses the commit
  function automatic md_result_t md_compute(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    md_result_t        r;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] sq;
    logic signed [31:0] sr;
    sa = $signed(a);
    sb = $signed(b);
    sq = '0;
    sr = '0;
    r.hilo  = '0;
    r.wr_en = 1'b1;
    case (op)
      MD_MULT: begin
        // Low 64 bits of a product of sign-extended operands equal the signed product
        r.hilo = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      end
      MD_MULTU: begin
        r.hilo = {32'b0, a} * {32'b0, b};
      end
      MD_DIV: begin
        if (b == 32'd0) begin
          r.wr_en = 1'b0;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          // The one overflowing signed quotient: defined as 0x80000000 rem 0
          r.hilo = {32'h0000_0000, 32'h8000_0000};
        end else begin
          sq     = sa / sb;
          sr     = sa % sb;
          r.hilo = {sr, sq};
        end
      end
      MD_DIVU: begin
        if (b == 32'd0) begin
          r.wr_en = 1'b0;
        end else begin
          r.hilo = {a % b, a / b};
        end
      end
      default: begin
        r.wr_en = 1'b0;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - EX-stage multiply/divide unit owning HI/LO; optional abort via MDU_ABORT_EN
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [31:0] D1,
  input  logic [31:0] D2,
  input  logic [2:0]  MDOp,
  input  logic        Start,
  input  logic        MDWe,
  input  logic        HiLo,
  input  logic        Abort,
  output logic        Busy,
  output logic [31:0] Out
);

  localparam int MAX_N = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W = ($clog2(MAX_N) > 0) ? $clog2(MAX_N) : 1;

  mdu_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]  hi_q, hi_d;
  logic [31:0]  lo_q, lo_d;
  logic [63:0]  res_q, res_d;
  logic         res_we_q, res_we_d;
  md_result_t   launch_res;
  logic         launch;

`ifndef MDU_ABORT_EN
  logic unused_abort;
  assign unused_abort = Abort;
`endif

  // Result of the op presented this cycle, evaluated in full at launch
  assign launch_res = md_compute(MDOp, D1, D2);
  assign launch     = Start && (MDOp <= MD_DIVU);

  // Launch, countdown, commit, MTHI/MTLO writes and abort
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_d    = res_q;
    res_we_d = res_we_q;
    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          // Start wins over a same-cycle MDWe
          res_d    = launch_res.hilo;
          res_we_d = launch_res.wr_en;
          state_d  = ST_BUSY;
          if (MDOp == MD_MULT || MDOp == MD_MULTU) begin
            cnt_d = CNT_W'(MULT_CYCLES - 1);
          end else begin
            cnt_d = CNT_W'(DIV_CYCLES - 1);
          end
        end else if (MDWe) begin
          if (HiLo == HILO_HI) begin
            hi_d = D1;
          end else begin
            lo_d = D1;
          end
        end
      end
      ST_BUSY: begin
`ifdef MDU_ABORT_EN
        if (Abort) begin
          // Abort outranks a same-edge commit
          state_d  = ST_IDLE;
          cnt_d    = '0;
          res_d    = '0;
          res_we_d = 1'b0;
        end else
`endif
        if (cnt_q == '0) begin
          state_d  = ST_IDLE;
          res_d    = '0;
          res_we_d = 1'b0;
          if (res_we_q) begin
            hi_d = res_q[63:32];
            lo_d = res_q[31:0];
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register; reset overrides an in-flight op
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_q    <= '0;
      res_we_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_q    <= res_d;
      res_we_q <= res_we_d;
    end
  end

  assign Busy = (state_q == ST_BUSY);
  assign Out  = (HiLo == HILO_HI) ? hi_q : lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit (abort cases under MDU_ABORT_EN)
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [31:0] D1, D2;
  logic [2:0]  MDOp;
  logic        Start, MDWe, HiLo, Abort;
  logic        Busy;
  logic [31:0] Out;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q[$];
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  mult_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .D1(D1), .D2(D2), .MDOp(MDOp), .Start(Start),
    .MDWe(MDWe), .HiLo(HiLo), .Abort(Abort), .Busy(Busy), .Out(Out)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic read_regs(output logic [31:0] hi, output logic [31:0] lo);
    HiLo = 1'b1; #1; hi = Out;
    HiLo = 1'b0; #1; lo = Out;
  endtask

  // Sign/magnitude reference model, independent of the operator-based RTL
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic        sgn;
    logic [31:0] ua, ub, q, r;
    logic [63:0] p;
    sgn = (op == MD_MULT) || (op == MD_DIV);
    ua  = (sgn && a[31]) ? -a : a;
    ub  = (sgn && b[31]) ? -b : b;
    if (op == MD_MULT || op == MD_MULTU) begin
      p = {32'b0, ua} * {32'b0, ub};
      if (sgn && (a[31] ^ b[31])) p = -p;
      return p;
    end
    if (b == 32'd0) return {model_hi, model_lo};
    q = ua / ub;
    r = ua % ub;
    if (sgn && (a[31] ^ b[31])) q = -q;
    if (sgn && a[31]) r = -r;
    return {r, q};
  endfunction

  // Drive one Start pulse; optional same-cycle MDWe to HI; returns at the first busy negedge
  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit with_we);
    logic [63:0] e;
    @(negedge Clk);
    D1 = a; D2 = b; MDOp = op; Start = 1'b1;
    if (with_we) begin MDWe = 1'b1; HiLo = 1'b1; end
    e = model(op, a, b);
    exp_q.push_back(e);
    {model_hi, model_lo} = e;
    @(negedge Clk);
    Start = 1'b0; MDWe = 1'b0; HiLo = 1'b0;
  endtask

  // Count busy negedges (pre already elapsed), then pop the scoreboard and compare HI/LO
  task automatic wait_commit(input string tag, input int n, input int pre);
    int          cyc;
    logic [31:0] h, l;
    logic [63:0] e;
    cyc = pre;
    while (Busy === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge Clk);
    end
    check({tag, "_busy"}, 64'(cyc), 64'(n));
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      read_regs(h, l);
      check({tag, "_hi"}, {32'b0, h}, {32'b0, e[63:32]});
      check({tag, "_lo"}, {32'b0, l}, {32'b0, e[31:0]});
    end
  endtask

  task automatic write_reg(input logic sel, input logic [31:0] v);
    @(negedge Clk);
    MDWe = 1'b1; HiLo = sel; D1 = v;
    @(negedge Clk);
    MDWe = 1'b0; HiLo = 1'b0;
    if (sel) model_hi = v; else model_lo = v;
  endtask

  task automatic check_regs(input string tag, input logic [31:0] eh, input logic [31:0] el);
    logic [31:0] h, l;
    read_regs(h, l);
    check({tag, "_hi"}, {32'b0, h}, {32'b0, eh});
    check({tag, "_lo"}, {32'b0, l}, {32'b0, el});
  endtask

  initial begin
    logic [31:0] h, l, a, b;
    logic [2:0]  op;
    Reset_n = 1'b0; D1 = '0; D2 = '0; MDOp = '0;
    Start = 1'b0; MDWe = 1'b0; HiLo = 1'b0; Abort = 1'b0;
    repeat (3) @(negedge Clk);
    check("reset_busy", {63'b0, Busy}, 64'd0);
    check_regs("reset", 32'h0, 32'h0);
    Reset_n = 1'b1;

    // Directed vectors with constant expectations
    launch(MD_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0);
    wait_commit("mult_neg", MULT_N, 0);
    check_regs("mult_neg_const", 32'hFFFF_FFFF, 32'hFFFF_FFF1);

    launch(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
    wait_commit("multu", MULT_N, 0);
    HiLo = 1'b1; #1; check("out_hi", {32'b0, Out}, 64'h1);
    HiLo = 1'b0; #1; check("out_lo", {32'b0, Out}, 64'hFFFF_FFFE);
    HiLo = 1'b1; #1; check("out_hi_again", {32'b0, Out}, 64'h1);
    HiLo = 1'b0;

    launch(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_commit("div_neg", DIV_N, 0);
    check_regs("div_neg_const", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    launch(MD_DIVU, 32'd7, 32'd0, 1'b0);
    wait_commit("divu_zero", DIV_N, 0);
    check_regs("divu_zero_const", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    launch(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_commit("div_ovf", DIV_N, 0);
    check_regs("div_ovf_const", 32'h0, 32'h8000_0000);

    launch(MD_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0);
    wait_commit("div_negdivisor", DIV_N, 0);

    // MTHI while idle, MTLO while busy is dropped
    write_reg(HILO_HI, 32'h1234_5678);
    check_regs("mthi", 32'h1234_5678, model_lo);
    launch(MD_MULTU, 32'd3, 32'd4, 1'b0);
    MDWe = 1'b1; HiLo = HILO_LO; D1 = 32'hDEAD_BEEF;
    @(negedge Clk);
    MDWe = 1'b0;
    wait_commit("mtlo_busy", MULT_N, 1);

    // Start while busy is ignored
    launch(MD_MULT, 32'd6, 32'hFFFF_FFFF, 1'b0);
    D1 = 32'd100; D2 = 32'd3; MDOp = MD_DIVU; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    wait_commit("start_busy", MULT_N, 1);

    // MDWe together with Start: Start wins
    launch(MD_MULTU, 32'h0001_0000, 32'h0001_0000, 1'b1);
    wait_commit("we_and_start", MULT_N, 0);

    // Reserved MDOp has no effect
    @(negedge Clk);
    MDOp = 3'd5; D1 = 32'd9; D2 = 32'd9; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    check("reserved_busy", {63'b0, Busy}, 64'd0);
    check_regs("reserved", model_hi, model_lo);

    // Random operations through the scoreboard
    for (int i = 0; i < 10; i++) begin
      op = 3'($urandom_range(0, 3));
      a  = $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 28);
      launch(op, a, b, 1'b0);
      wait_commit($sformatf("rand%0d", i), (op <= MD_MULTU) ? MULT_N : DIV_N, 0);
    end

`ifdef MDU_ABORT_EN
    // Abort mid-flight, then abort on the commit edge
    h = model_hi; l = model_lo;
    @(negedge Clk);
    D1 = 32'd50; D2 = 32'd7; MDOp = MD_DIV; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (2) @(negedge Clk);
    Abort = 1'b1;
    @(negedge Clk);
    Abort = 1'b0;
    check("abort_busy", {63'b0, Busy}, 64'd0);
    check_regs("abort", h, l);
    @(negedge Clk);
    D1 = 32'd50; D2 = 32'd7; MDOp = MD_DIV; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (DIV_N - 1) @(negedge Clk);
    check("abort_late_busy_before", {63'b0, Busy}, 64'd1);
    Abort = 1'b1;
    @(negedge Clk);
    Abort = 1'b0;
    check("abort_late_busy", {63'b0, Busy}, 64'd0);
    check_regs("abort_late", h, l);
`endif

    // Reset while a MULT is in flight
    launch(MD_MULT, 32'd11, 32'd13, 1'b0);
    @(negedge Clk);
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    exp_q.delete();
    model_hi = '0; model_lo = '0;
    check("midreset_busy", {63'b0, Busy}, 64'd0);
    check_regs("midreset", 32'h0, 32'h0);
    repeat (MULT_N + 3) @(negedge Clk);
    check("midreset_late_busy", {63'b0, Busy}, 64'd0);
    check_regs("midreset_late", 32'h0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
